adc_stream_arbiter: RTL and testbench
=====================================

// Module: adc_stream_arbiter
// PURPOSE
//  Round-robin burst arbiter: shares one 128-bit AXIS path (upstream of axis_pl_to_ps) among NUM_CH ADC channel streams.
//  Grants one channel per burst of BURST_LEN beats and marks the last beat with tlast.
//  Tags each beat with its channel ID so the PS can demultiplex readout data.
//  Sits between the per-channel adc_ctrl sample FIFOs and the PL->PS width converter.
// PARAMETERS
//  NUM_CH     4    number of requesting channel streams (2..16)
//  DATA_W     128  AXIS data width (8 x 16-bit samples)
//  BURST_LEN  16   beats transferred per grant (>=1)
//  CH_W       $clog2(NUM_CH)  width of channel-ID fields (derived, not overridden)
// PORTS
//  clk            in   1              PL clock; all logic is on this clock
//  rst            in   1              asynchronous, active-low reset
//  enable         in   1              1 = arbitration allowed; 0 = no new grants
//  s_axis_tdata   in   NUM_CH*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W]
//  s_axis_tvalid  in   NUM_CH         per-channel valid
//  s_axis_tready  out  NUM_CH         per-channel ready; only the granted bit can be 1
//  m_axis_tdata   out  DATA_W         muxed data of the granted channel
//  m_axis_tvalid  out  1              = s_axis_tvalid[grant_ch] while in XFER, else 0
//  m_axis_tready  in   1              downstream ready
//  m_axis_tlast   out  1              1 on the final beat of each burst
//  m_axis_tuser   out  CH_W           channel ID of the current beat (= grant_ch)
//  grant_ch       out  CH_W           currently or last granted channel
//  busy           out  1              1 while in XFER
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, rr_ptr=0, beat_cnt=0, grant_ch=0.
//   All s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, busy=0.
//   Reset mid-burst aborts immediately; there is no partial-burst recovery.
//  Handshake: a beat transfers on a clk edge where m_axis_tvalid & m_axis_tready = 1.
//  FSM states: IDLE, XFER.
//   IDLE: if enable=1 and any s_axis_tvalid=1, grant the first valid channel
//    at or after rr_ptr (modulo NUM_CH). Register grant_ch, clear beat_cnt, go to XFER.
//    Otherwise remain in IDLE.
//   XFER: pass-through is combinational from the registered grant:
//    m_axis_tdata  = slice[grant_ch];  m_axis_tvalid = s_axis_tvalid[grant_ch]
//    s_axis_tready = onehot(grant_ch) & {NUM_CH{m_axis_tready}}
//    m_axis_tlast  = (beat_cnt == BURST_LEN-1)
//    beat_cnt increments on each beat.
//    On the beat with tlast: rr_ptr <= grant_ch+1 (wraps to 0 after NUM_CH-1); go to IDLE.
//  Latency: request in IDLE -> first m_axis_tvalid one cycle later. Minimum gap between bursts is 1 idle cycle.
//  The grant is locked for the full burst.
//   A stalled source (tvalid low) or sink (tready low) holds the state; there is no timeout.
//   Other channels' valids are ignored during a burst.
//  If enable falls mid-burst, the burst completes; no new grant is made while enable=0.
//  Simultaneous requests are resolved by round-robin: no channel gets two consecutive bursts while another is requesting.
//  BURST_LEN=1: every beat carries tlast, and the FSM returns to IDLE after each beat.
//  beat_cnt width is $clog2(BURST_LEN+1). tdata and tuser values are don't-care when tvalid=0.
// TESTING
//  1. Hold rst=0, drive all channels valid
//     -> all s_axis_tready=0, m_axis_tvalid=0, busy=0 throughout.
//  2. Only ch2 valid, data 0x0000_1111_..._7777 +beat; tready=1; BURST_LEN=16
//     -> 16 beats with tuser=2, tlast on beat 15 only, first tvalid 1 cycle after request.
//  3. All 4 channels continuously valid
//     -> grants in order 0,1,2,3,0; each burst is 16 beats; one idle cycle between bursts.
//  4. Toggle m_axis_tready every cycle mid-burst
//     -> no beat dropped or duplicated; the source data sequence is reproduced exactly; tlast still on beat 16.
//  5. Deassert enable at beat 5 of a ch1 burst
//     -> the burst completes 16 beats; busy=0 afterwards; no grant until enable=1, which then grants ch2 if valid.
//  6. Assert rst low at beat 7
//     -> outputs go to reset values immediately. After release, ch0 is requested first (rr_ptr=0) and beat_cnt restarts at 0.

Source files
------------

// File: rtl/adc_stream_arbiter.sv
// rtl/adc_stream_arbiter.sv - round-robin burst arbiter muxing ADC channel streams onto one AXIS path
// Each grant is locked for BURST_LEN beats; tuser carries the channel ID for PS-side demux.
module adc_stream_arbiter #(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 128,
  parameter int BURST_LEN = 16,
  localparam int CH_W     = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [NUM_CH*DATA_W-1:0] s_axis_tdata,
  input  logic [NUM_CH-1:0]        s_axis_tvalid,
  output logic [NUM_CH-1:0]        s_axis_tready,
  output logic [DATA_W-1:0]        m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast,
  output logic [CH_W-1:0]          m_axis_tuser,
  output logic [CH_W-1:0]          grant_ch,
  output logic                     busy
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t            state_q, state_d;
  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   grant_q;
  logic [CNT_W-1:0]  beat_cnt;
  logic [CH_W-1:0]   pick_ch;
  logic [CH_W-1:0]   scan_idx;
  logic              pick_found;
  logic              xfer;
  logic              beat;
  logic              last_beat;
  logic [DATA_W-1:0] ch_data [NUM_CH];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_slice
    assign ch_data[c] = s_axis_tdata[c*DATA_W +: DATA_W];
  end

  // First requesting channel at or after rr_ptr, wrapping modulo NUM_CH.
  always_comb begin
    pick_found = 1'b0;
    pick_ch    = '0;
    scan_idx   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      scan_idx = CH_W'((int'(rr_ptr) + i) % NUM_CH);
      if (!pick_found && s_axis_tvalid[scan_idx]) begin
        pick_found = 1'b1;
        pick_ch    = scan_idx;
      end
    end
  end

  assign xfer          = (state_q == XFER);
  assign last_beat     = (beat_cnt == CNT_W'(BURST_LEN - 1));
  assign m_axis_tdata  = ch_data[grant_q];
  assign m_axis_tvalid = xfer & s_axis_tvalid[grant_q];
  assign m_axis_tlast  = xfer & last_beat;
  assign m_axis_tuser  = grant_q;
  assign grant_ch      = grant_q;
  assign busy          = xfer;
  assign beat          = m_axis_tvalid & m_axis_tready;
  assign s_axis_tready = xfer ? ((NUM_CH'(1) << grant_q) & {NUM_CH{m_axis_tready}}) : '0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable && pick_found) state_d = XFER;
      XFER:    if (beat && last_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      rr_ptr   <= '0;
      grant_q  <= '0;
      beat_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && state_d == XFER) begin
        grant_q  <= pick_ch;
        beat_cnt <= '0;
      end else if (beat) begin
        beat_cnt <= beat_cnt + CNT_W'(1);
        if (last_beat) begin
          rr_ptr   <= (grant_q == CH_W'(NUM_CH - 1)) ? '0 : grant_q + CH_W'(1);
          beat_cnt <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_stream_arbiter.sv
// tb/tb_adc_stream_arbiter.sv - directed self-checking bench for adc_stream_arbiter
module tb_adc_stream_arbiter;

  localparam int NUM_CH    = 4;
  localparam int DATA_W    = 128;
  localparam int BURST_LEN = 16;
  localparam int CH_W      = 2;
  localparam logic [DATA_W-1:0] PATTERN = 128'h0000_1111_2222_3333_4444_5555_6666_7777;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     enable;
  logic [NUM_CH*DATA_W-1:0] s_axis_tdata;
  logic [NUM_CH-1:0]        s_axis_tvalid;
  logic [NUM_CH-1:0]        s_axis_tready;
  logic [DATA_W-1:0]        m_axis_tdata;
  logic                     m_axis_tvalid;
  logic                     m_axis_tready;
  logic                     m_axis_tlast;
  logic [CH_W-1:0]          m_axis_tuser;
  logic [CH_W-1:0]          grant_ch;
  logic                     busy;

  adc_stream_arbiter #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser), .grant_ch(grant_ch), .busy(busy)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int src_idx [NUM_CH];
  int exp_idx [NUM_CH];

  logic              hs, hs_last, obs_valid, obs_busy;
  logic [CH_W-1:0]   hs_ch;
  logic [DATA_W-1:0] hs_data;
  logic [NUM_CH-1:0] obs_tready;

  logic [CH_W-1:0]   got_ch   [BURST_LEN];
  logic [DATA_W-1:0] got_data [BURST_LEN];
  logic              got_last [BURST_LEN];
  int                got_n, got_lat;

  function automatic logic [DATA_W-1:0] exp_data(int c, int n);
    return PATTERN + (DATA_W'(c) << 120) + DATA_W'(n);
  endfunction

  task automatic drive_data();
    for (int c = 0; c < NUM_CH; c++) s_axis_tdata[c*DATA_W +: DATA_W] = exp_data(c, src_idx[c]);
  endtask

  // Sample at negedge, then advance the source that was accepted at the posedge.
  task automatic tick();
    @(negedge clk);
    obs_valid  = m_axis_tvalid;
    obs_busy   = busy;
    obs_tready = s_axis_tready;
    hs         = m_axis_tvalid & m_axis_tready;
    hs_ch      = m_axis_tuser;
    hs_data    = m_axis_tdata;
    hs_last    = m_axis_tlast;
    @(posedge clk);
    #1;
    if (hs) begin
      src_idx[hs_ch] = src_idx[hs_ch] + 1;
      drive_data();
    end
  endtask

  task automatic collect_burst(input bit toggle_ready, input int drop_en_at);
    got_n   = 0;
    got_lat = -1;
    for (int t = 0; t < 100; t++) begin
      tick();
      if (hs) begin
        if (got_lat < 0) got_lat = t;
        got_ch[got_n]   = hs_ch;
        got_data[got_n] = hs_data;
        got_last[got_n] = hs_last;
        got_n++;
        if (got_n == drop_en_at) enable = 1'b0;
        if (hs_last || got_n == BURST_LEN) break;
      end
      if (toggle_ready) m_axis_tready = ~m_axis_tready;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; enable = 1'b1; m_axis_tready = 1'b1; s_axis_tvalid = '1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total_cnt++;
      if ({obs_tready, obs_valid, obs_busy} !== '0)
        $display("FAIL reset_outputs cyc%0d got tready=%b tvalid=%b busy=%b want all 0", i, obs_tready, obs_valid, obs_busy);
      else pass_cnt++;
    end
    total_cnt++;
    if ({grant_ch, m_axis_tlast} !== '0) $display("FAIL reset_grant got grant=%0d tlast=%b want 0/0", grant_ch, m_axis_tlast);
    else pass_cnt++;
    rst = 1'b1;
  endtask

  task automatic test_round_robin();
    int ch;
    for (int b = 0; b < 5; b++) begin
      ch = b % NUM_CH;
      collect_burst(1'b0, -1);
      if (b == 4) s_axis_tvalid = '0;
      total_cnt++;
      if (got_n !== BURST_LEN || got_lat !== 1)
        $display("FAIL rr_burst%0d got beats=%0d lat=%0d want %0d/1", b, got_n, got_lat, BURST_LEN);
      else pass_cnt++;
      for (int i = 0; i < got_n; i++) begin
        total_cnt++;
        if (got_ch[i] !== CH_W'(ch) || got_data[i] !== exp_data(ch, exp_idx[ch]) || got_last[i] !== (i == BURST_LEN-1))
          $display("FAIL rr_beat b%0d i%0d got ch=%0d data=%h last=%b want ch=%0d data=%h last=%b",
                   b, i, got_ch[i], got_data[i], got_last[i], ch, exp_data(ch, exp_idx[ch]), (i == BURST_LEN-1));
        else pass_cnt++;
        exp_idx[ch]++;
      end
    end
  endtask

  task automatic run_single(input string name, input int ch, input bit toggle, input bit chk_lat);
    collect_burst(toggle, -1);
    s_axis_tvalid = '0;
    m_axis_tready = 1'b1;
    total_cnt++;
    if (got_n !== BURST_LEN || (chk_lat && got_lat !== 1))
      $display("FAIL %s_count got beats=%0d lat=%0d want %0d/1", name, got_n, got_lat, BURST_LEN);
    else pass_cnt++;
    for (int i = 0; i < got_n; i++) begin
      total_cnt++;
      if (got_ch[i] !== CH_W'(ch) || got_data[i] !== exp_data(ch, exp_idx[ch]) || got_last[i] !== (i == BURST_LEN-1))
        $display("FAIL %s_beat i%0d got ch=%0d data=%h last=%b want ch=%0d data=%h last=%b",
                 name, i, got_ch[i], got_data[i], got_last[i], ch, exp_data(ch, exp_idx[ch]), (i == BURST_LEN-1));
      else pass_cnt++;
      exp_idx[ch]++;
    end
    tick();
    total_cnt++;
    if (obs_busy !== 1'b0) $display("FAIL %s_idle got busy=%b want 0", name, obs_busy);
    else pass_cnt++;
  endtask

  task automatic test_single_channel();
    s_axis_tvalid = 4'b0100;
    run_single("single_ch2", 2, 1'b0, 1'b1);
  endtask

  task automatic test_backpressure();
    s_axis_tvalid = 4'b1000;
    run_single("toggle_ch3", 3, 1'b1, 1'b0);
  endtask

  task automatic test_enable_drop();
    s_axis_tvalid = 4'b0110;
    collect_burst(1'b0, 5);
    total_cnt++;
    if (got_n !== BURST_LEN || got_ch[0] !== CH_W'(1) || got_last[BURST_LEN-1] !== 1'b1)
      $display("FAIL en_drop_burst got beats=%0d ch=%0d want %0d beats ch=1", got_n, got_ch[0], BURST_LEN);
    else pass_cnt++;
    exp_idx[1] += got_n;
    s_axis_tvalid = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++;
      if (obs_busy !== 1'b0 || obs_tready !== '0)
        $display("FAIL en_low_idle cyc%0d got busy=%b tready=%b want 0", i, obs_busy, obs_tready);
      else pass_cnt++;
    end
    enable = 1'b1;
    run_single("en_regrant_ch2", 2, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid_burst();
    int n = 0;
    s_axis_tvalid = '1;
    for (int t = 0; t < 40 && n < 7; t++) begin
      tick();
      if (hs) begin
        total_cnt++;
        if (hs_ch !== CH_W'(3) || hs_data !== exp_data(3, exp_idx[3]))
          $display("FAIL abort_beat i%0d got ch=%0d data=%h want ch=3 data=%h", n, hs_ch, hs_data, exp_data(3, exp_idx[3]));
        else pass_cnt++;
        exp_idx[3]++;
        n++;
      end
    end
    rst = 1'b0;
    #1;
    total_cnt++;
    if ({s_axis_tready, m_axis_tvalid, m_axis_tlast, busy, grant_ch} !== '0)
      $display("FAIL abort_async got tready=%b tvalid=%b tlast=%b busy=%b grant=%0d want 0",
               s_axis_tready, m_axis_tvalid, m_axis_tlast, busy, grant_ch);
    else pass_cnt++;
    tick();
    tick();
    rst = 1'b1;
    run_single("post_reset_ch0", 0, 1'b0, 1'b1);
  endtask

  initial begin
    for (int c = 0; c < NUM_CH; c++) begin
      src_idx[c] = 0;
      exp_idx[c] = 0;
    end
    s_axis_tdata = '0;
    drive_data();
    test_reset();
    test_round_robin();
    test_single_channel();
    test_backpressure();
    test_enable_drop();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
